packet_buffer_fifo: RTL and testbench

- Parametrised circular packet buffer for the UDP/TCP datapath; successor to the fixed 32-bit, 16K-word, non-wrapping buffer.
- Write pointer, read pointer and count wrap, so the buffer is reusable indefinitely.
- The write side stages a packet speculatively, then commits it (makes it readable) or discards it (rolls it back), e.g. after a checksum failure.
- Sits between the RX header/checksum stage and the application read port.

---
 rtl/packet_buffer_fifo_pkg.sv | 23 ++
 rtl/packet_buffer_fifo_ram.sv | 27 ++
 rtl/packet_buffer_fifo.sv | 87 ++++++++
 tb/tb_packet_buffer_fifo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/packet_buffer_fifo_pkg.sv
// Shared constants and pointer helpers for the circular packet buffer.
package packet_buffer_fifo_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 14;

  function automatic int unsigned ptr_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

  // Modulo-2**ptr_w subtraction carried out in a 32-bit container.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'(1) << ptr_w) - 32'(1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/packet_buffer_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port; array is not reset.
module buffer_ram_dp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/packet_buffer_fifo.sv
// Circular packet buffer with speculative staging, commit and discard on the write side.
module packet_buffer_fifo
  import packet_buffer_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  input  logic              wr_commit,
  input  logic              wr_discard,
  output logic              full,
  output logic              wr_overflow,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              data_av,
  output logic [ADDR_W:0]   level
);

  localparam int unsigned PTR_W = ptr_width(ADDR_W);
  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [PTR_W-1:0] wr_ptr, cm_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_inc;
  logic             wr_accept, wr_drop, rd_accept, abort;

  assign full    = ptr_diff(32'(wr_ptr), 32'(rd_ptr), PTR_W) == 32'(DEPTH);
  assign data_av = cm_ptr != rd_ptr;
  assign level   = (ADDR_W+1)'(ptr_diff(32'(cm_ptr), 32'(rd_ptr), PTR_W));

  assign wr_accept  = wr_en && !full && !wr_discard;
  assign wr_drop    = wr_en && full;
  assign rd_accept  = rd_en && data_av;
  assign wr_ptr_inc = wr_ptr + PTR_W'(wr_accept);
  // A packet that lost any word, now or earlier, is rolled back instead of committed.
  assign abort      = wr_overflow || wr_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      cm_ptr      <= '0;
      wr_overflow <= 1'b0;
    end else if (wr_discard) begin
      wr_ptr      <= cm_ptr;
      wr_overflow <= 1'b0;
    end else if (wr_commit) begin
      wr_overflow <= 1'b0;
      if (abort) begin
        wr_ptr <= cm_ptr;
      end else begin
        wr_ptr <= wr_ptr_inc;
        cm_ptr <= wr_ptr_inc;
      end
    end else begin
      wr_ptr <= wr_ptr_inc;
      if (wr_drop) wr_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr + PTR_W'(rd_accept);
      rd_valid <= rd_accept;
    end
  end

  buffer_ram_dp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (wr_accept),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(data_in),
    .re   (rd_accept),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(data_out)
  );

endmodule

// File: tb/tb_packet_buffer_fifo.sv
// Self-checking bench for packet_buffer_fifo: queue-based packet model plus directed checks.
module tb_packet_buffer_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic              wr_en, wr_commit, wr_discard, rd_en;
  logic              full, wr_overflow, rd_valid, data_av;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W:0]   level;

  int n_cmp = 0;
  int n_bad = 0;

  packet_buffer_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en),
    .wr_commit(wr_commit), .wr_discard(wr_discard), .full(full),
    .wr_overflow(wr_overflow), .rd_en(rd_en), .data_out(data_out),
    .rd_valid(rd_valid), .data_av(data_av), .level(level)
  );

  always #5 clk = ~clk;

  // Model: committed and staged packets as queues of words.
  logic [DATA_W-1:0] cq[$];
  logic [DATA_W-1:0] sq[$];
  logic [DATA_W-1:0] m_dout;
  logic              m_rv, m_ovf;

  always @(posedge clk) begin
    bit m_full, ok, drop;
    if (reset) begin
      cq.delete(); sq.delete();
      m_dout = '0; m_rv = 1'b0; m_ovf = 1'b0;
    end else begin
      m_full = (cq.size() + sq.size()) == DEPTH;
      ok     = wr_en && !m_full;
      drop   = wr_en && m_full;
      if (rd_en && cq.size() > 0) begin
        m_dout = cq.pop_front();
        m_rv   = 1'b1;
      end else begin
        m_rv = 1'b0;
      end
      if (wr_discard) begin
        sq.delete(); m_ovf = 1'b0;
      end else if (wr_commit) begin
        if (!(m_ovf || drop)) begin
          if (ok) sq.push_back(data_in);
          foreach (sq[i]) cq.push_back(sq[i]);
        end
        sq.delete(); m_ovf = 1'b0;
      end else begin
        if (ok) sq.push_back(data_in);
        if (drop) m_ovf = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle once reset has been applied.
  bit started = 1'b0;
  always @(negedge clk) begin
    if (started) begin
      chk("m_full",    32'(full),        32'((cq.size() + sq.size()) == DEPTH));
      chk("m_data_av", 32'(data_av),     32'(cq.size() > 0));
      chk("m_level",   32'(level),       32'(cq.size()));
      chk("m_ovf",     32'(wr_overflow), 32'(m_ovf));
      chk("m_rv",      32'(rd_valid),    32'(m_rv));
      chk("m_dout",    data_out,         m_dout);
    end
  end

  task automatic cyc(input bit we, input logic [31:0] d, input bit cm, input bit ds, input bit re);
    wr_en = we; data_in = d; wr_commit = cm; wr_discard = ds; rd_en = re;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit saw_full;
    int exp_v;
    reset = 1'b1; wr_en = 0; wr_commit = 0; wr_discard = 0; rd_en = 0; data_in = '0;
    @(posedge clk); @(negedge clk);
    started = 1'b1;
    cyc(0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("rst_level", 32'(level), 0);
    chk("rst_data_av", 32'(data_av), 0);
    chk("rst_full", 32'(full), 0);

    // Basic ordering
    cyc(1, 32'h11, 0, 0, 0);
    cyc(1, 32'h22, 0, 0, 0);
    chk("pre_commit_av", 32'(data_av), 0);
    cyc(1, 32'h33, 1, 0, 0);
    chk("post_commit_av", 32'(data_av), 1);
    chk("post_commit_level", 32'(level), 3);
    cyc(0, 0, 0, 0, 1);
    chk("rd1", data_out, 32'h11); chk("rd1_v", 32'(rd_valid), 1); chk("rd1_lvl", 32'(level), 2);
    cyc(0, 0, 0, 0, 1);
    chk("rd2", data_out, 32'h22);
    cyc(0, 0, 0, 0, 1);
    chk("rd3", data_out, 32'h33); chk("rd3_lvl", 32'(level), 0);
    cyc(0, 0, 0, 0, 1);
    chk("rd4_v", 32'(rd_valid), 0); chk("rd4_hold", data_out, 32'h33);

    // Discard
    cyc(1, 32'hA0, 0, 0, 0);
    cyc(1, 32'hA1, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 32'hB0 + 32'(i), 0, 0, 0);
    chk("stage_level", 32'(level), 2);
    cyc(0, 0, 0, 1, 0);
    chk("disc_level", 32'(level), 2);
    cyc(1, 32'hC0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1); chk("disc_rd1", data_out, 32'hA0);
    cyc(0, 0, 0, 0, 1); chk("disc_rd2", data_out, 32'hA1);
    cyc(0, 0, 0, 0, 1); chk("disc_rd3", data_out, 32'hC0);

    // Wrap-around: 24 words streamed with per-word commit and concurrent reads
    saw_full = 0; exp_v = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(i < 24, 32'(i), i < 24, 0, i > 0);
      if (full) saw_full = 1;
      if (rd_valid) begin
        chk("wrap_data", data_out, 32'(exp_v));
        exp_v++;
      end
    end
    chk("wrap_count", 32'(exp_v), 24);
    chk("wrap_no_full", 32'(saw_full), 0);

    // Full and overflow
    for (int i = 0; i < 10; i++) begin
      cyc(1, 32'h100 + 32'(i), 0, 0, 0);
      if (i == 6) chk("full_at7", 32'(full), 0);
      if (i == 7) begin chk("full_at8", 32'(full), 1); chk("ovf_at8", 32'(wr_overflow), 0); end
      if (i == 8) chk("ovf_at9", 32'(wr_overflow), 1);
    end
    cyc(0, 0, 1, 0, 0);
    chk("ovf_commit_level", 32'(level), 0);
    chk("ovf_commit_ovf", 32'(wr_overflow), 0);
    chk("ovf_commit_full", 32'(full), 0);

    // Concurrent read, write and commit
    for (int i = 0; i < 4; i++) cyc(1, 32'h200 + 32'(i), i == 3, 0, 0);
    chk("conc_pre_level", 32'(level), 4);
    cyc(1, 32'h255, 1, 0, 1);
    chk("conc_rv", 32'(rd_valid), 1);
    chk("conc_data", data_out, 32'h200);
    chk("conc_level", 32'(level), 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    chk("conc_last", data_out, 32'h255);

    // Reset mid-operation
    cyc(1, 32'h300, 0, 0, 0);
    cyc(1, 32'h301, 1, 0, 0);
    cyc(1, 32'h302, 0, 0, 1);
    cyc(1, 32'h303, 0, 0, 0);
    cyc(1, 32'h304, 0, 0, 0);
    chk("pre_rst_dout", data_out, 32'h300);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("mrst_level", 32'(level), 0);
    chk("mrst_av", 32'(data_av), 0);
    chk("mrst_full", 32'(full), 0);
    chk("mrst_rv", 32'(rd_valid), 0);
    chk("mrst_dout", data_out, 0);
    cyc(0, 0, 0, 0, 1);
    chk("mrst_rd_ignored", 32'(rd_valid), 0);

    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
